line_buffer_read_ctrl: RTL and testbench

Controller on the consumer side of four line_buffer_datapath instances. It steers an incoming pixel stream into one buffer at a time in round-robin order. Once three complete lines are stored, it reads three buffers in lock-step and emits one vertically aligned 3-pixel column per cycle (top/mid/bot). It sits between the pixel source and the 3x3 window/kernel stages.

---
 rtl/line_buffer_read_ctrl.sv | 175 +++++++++++++++++
 tb/tb_line_buffer_read_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_read_ctrl.sv
// line_buffer_read_ctrl
// Consumer-side controller for four line_buffer_datapath instances. Incoming
// pixels are steered round-robin into one buffer at a time. Once three full
// lines are held, three buffers are read in lock-step and one vertically
// aligned column (top = oldest line, bot = newest line) is produced per cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        synchronous clear of all state (frame restart)
//   pix_valid_i    source has a pixel this cycle
//   ready_o        a pixel is accepted this cycle when pix_valid_i is high
//   wr_en_o[3:0]   one-hot write enable to buffers 0..3
//   rd_en_o[3:0]   read enables to buffers 0..3 (three bits set while reading)
//   rd_data_i[31:0] buffer data outputs, buffer k on bits [8k+7:8k]
//   col_valid_o    column outputs valid
//   col_top_o/col_mid_o/col_bot_o  oldest/middle/newest line pixel
//   line_done_o    pulse with the last column of a line
module line_buffer_read_ctrl #(
    parameter int unsigned WIDTH = 640,
    parameter int unsigned CNT_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        pix_valid_i,
    output logic        ready_o,
    output logic [3:0]  wr_en_o,
    output logic [3:0]  rd_en_o,
    input  logic [31:0] rd_data_i,
    output logic        col_valid_o,
    output logic [7:0]  col_top_o,
    output logic [7:0]  col_mid_o,
    output logic [7:0]  col_bot_o,
    output logic        line_done_o
);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_READ   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       rd_sel_q, rd_sel_d;
    logic [2:0]       avail_q, avail_d;
    logic             col_valid_q, col_valid_d;
    logic [1:0]       sel_d_q, sel_d_d;
    logic             line_done_q, line_done_d;

    logic [1:0] wr_sel;
    logic       accept;
    logic       line_wr_done;
    logic       rd_active;
    logic       rd_last;
    logic [1:0] sel_mid;
    logic [1:0] sel_bot;

    // Write side: the next free buffer sits right after the held lines.
    assign wr_sel       = rd_sel_q + avail_q[1:0];
    assign ready_o      = (avail_q < 3'd4);
    assign accept       = pix_valid_i & ready_o & ~flush_i;
    assign line_wr_done = accept & (wr_cnt_q == CNT_LAST);
    assign rd_active    = (state_q == S_READ);
    assign rd_last      = rd_active & (rd_cnt_q == CNT_LAST);

    always_comb begin
        wr_en_o = 4'b0000;
        if (accept) begin
            wr_en_o[wr_sel] = 1'b1;
        end
    end

    // Read side: the three oldest buffers, gated off during a flush cycle.
    always_comb begin
        rd_en_o = 4'b0000;
        if (rd_active && !flush_i) begin
            rd_en_o[rd_sel_q]         = 1'b1;
            rd_en_o[rd_sel_q + 2'd1]  = 1'b1;
            rd_en_o[rd_sel_q + 2'd2]  = 1'b1;
        end
    end

    // Next-state logic; flush overrides everything else.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rd_sel_d    = rd_sel_q;
        avail_d     = avail_q;
        col_valid_d = rd_active;
        sel_d_d     = rd_sel_q;
        line_done_d = rd_last;

        if (flush_i) begin
            state_d     = S_IDLE;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            rd_sel_d    = 2'd0;
            avail_d     = 3'd0;
            col_valid_d = 1'b0;
            sel_d_d     = 2'd0;
            line_done_d = 1'b0;
        end else begin
            if (accept) begin
                wr_cnt_d = line_wr_done ? '0 : wr_cnt_q + CNT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (avail_q >= 3'd3) begin
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    if (rd_last) begin
                        rd_cnt_d = '0;
                        rd_sel_d = rd_sel_q + 2'd1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A line finishing while a burst retires leaves the count unchanged.
            case ({line_wr_done, rd_last})
                2'b10:   avail_d = avail_q + 3'd1;
                2'b01:   avail_d = avail_q - 3'd1;
                default: avail_d = avail_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            rd_sel_q    <= 2'd0;
            avail_q     <= 3'd0;
            col_valid_q <= 1'b0;
            sel_d_q     <= 2'd0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_sel_q    <= rd_sel_d;
            avail_q     <= avail_d;
            col_valid_q <= col_valid_d;
            sel_d_q     <= sel_d_d;
            line_done_q <= line_done_d;
        end
    end

    // Buffer data is registered on rd_en, so the column is picked with the
    // buffer selection delayed by one cycle to line up with it.
    assign sel_mid = sel_d_q + 2'd1;
    assign sel_bot = sel_d_q + 2'd2;

    always_comb begin
        col_top_o = 8'd0;
        col_mid_o = 8'd0;
        col_bot_o = 8'd0;
        if (col_valid_q) begin
            col_top_o = rd_data_i[{sel_d_q, 3'b000} +: 8];
            col_mid_o = rd_data_i[{sel_mid, 3'b000} +: 8];
            col_bot_o = rd_data_i[{sel_bot, 3'b000} +: 8];
        end
    end

    assign col_valid_o = col_valid_q;
    assign line_done_o = line_done_q;

endmodule

// File: tb/tb_line_buffer_read_ctrl.sv
// Bench for line_buffer_read_ctrl with WIDTH=4: models the four attached line
// buffers, predicts every column from the pixels it streams in, and checks
// write steering, burst timing, backpressure, flush and async reset.
module tb_line_buffer_read_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        pix_valid_i;
    logic        ready_o;
    logic [3:0]  wr_en_o;
    logic [3:0]  rd_en_o;
    logic [31:0] rd_data_i;
    logic        col_valid_o;
    logic [7:0]  col_top_o;
    logic [7:0]  col_mid_o;
    logic [7:0]  col_bot_o;
    logic        line_done_o;

    line_buffer_read_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .pix_valid_i (pix_valid_i),
        .ready_o     (ready_o),
        .wr_en_o     (wr_en_o),
        .rd_en_o     (rd_en_o),
        .rd_data_i   (rd_data_i),
        .col_valid_o (col_valid_o),
        .col_top_o   (col_top_o),
        .col_mid_o   (col_mid_o),
        .col_bot_o   (col_bot_o),
        .line_done_o (line_done_o)
    );

    always #5 clk = ~clk;

    // Pixel currently presented by the source; it goes straight to the buffers.
    logic [7:0] cur_pix;

    // Four line buffers (DEPTH == WIDTH), data_o registered on rd_en.
    // They restart with the frame, on reset as well as on flush.
    logic [7:0]  mem [4][WIDTH];
    int          wp [4];
    int          rp [4];
    logic [31:0] rd_data_q;
    assign rd_data_i = rd_data_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            for (int k = 0; k < 4; k++) begin
                wp[k] <= 0;
                rp[k] <= 0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < 4; k++) begin
                wp[k] <= 0;
                rp[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_en_o[k]) begin
                    mem[k][wp[k]] <= cur_pix;
                    wp[k] <= (wp[k] == int'(WIDTH) - 1) ? 0 : wp[k] + 1;
                end
                if (rd_en_o[k]) begin
                    rd_data_q[8*k +: 8] <= mem[k][rp[k]];
                    rp[k] <= (rp[k] == int'(WIDTH) - 1) ? 0 : rp[k] + 1;
                end
            end
        end
    end

    // Scoreboard state
    logic [24:0] exp_q[$];
    logic [7:0]  lines [64][WIDTH];
    int n_lines, col_pos, cyc_no, rd_run, gap_cnt, third_cyc;
    int stall_seen, tie_seen;
    bit gap_pending, await_read;
    int n_vec, n_miss;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic sb_reset();
        exp_q.delete();
        n_lines     = 0;
        col_pos     = 0;
        rd_run      = 0;
        gap_cnt     = 0;
        gap_pending = 1'b0;
        await_read  = 1'b0;
    endtask

    // Columns of burst b: line b on top, line b+2 at the bottom.
    task automatic push_burst(input int b);
        logic [24:0] e;
        for (int i = 0; i < int'(WIDTH); i++) begin
            e = {lines[b][i], lines[b+1][i], lines[b+2][i], 1'(i == int'(WIDTH) - 1)};
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        logic [24:0] e;
        if (rd_en_o != 4'b0000) begin
            // One IDLE cycle separates the third line's completion from the read.
            if (rd_run == 0 && await_read) begin
                check("read_start", 32'(cyc_no - third_cyc), 32'd2);
                await_read = 1'b0;
            end
            rd_run++;
        end else begin
            rd_run = 0;
        end

        if (col_valid_o) begin
            if (gap_pending) begin
                check("burst_gap", 32'(gap_cnt), 32'd1);
                gap_pending = 1'b0;
            end
            if (exp_q.size() == 0) begin
                check("col_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("column", 32'({col_top_o, col_mid_o, col_bot_o, line_done_o}), 32'(e));
            end
            // Next burst's lines were already complete: it must follow after 1 idle cycle.
            if (line_done_o && exp_q.size() != 0) begin
                gap_pending = 1'b1;
                gap_cnt     = 0;
            end
        end else begin
            if (gap_pending) gap_cnt++;
            check("idle_cols", 32'({col_top_o, col_mid_o, col_bot_o, line_done_o}), 32'd0);
        end
    endtask

    // One clock cycle: drive at posedge+1, observe at negedge.
    task automatic step(input bit valid, input bit flush, output bit acc);
        logic [3:0] exp_we;
        pix_valid_i = valid;
        flush_i     = flush;
        @(negedge clk);
        monitor();
        acc = valid && ready_o && !flush;
        if (acc) begin
            exp_we = 4'b0000;
            exp_we[n_lines % 4] = 1'b1;
            check("wr_en", 32'(wr_en_o), 32'(exp_we));
            if (rd_run == int'(WIDTH) && col_pos == int'(WIDTH) - 1) tie_seen++;
            if (n_lines < 64) lines[n_lines][col_pos] = cur_pix;
            col_pos++;
            if (col_pos == int'(WIDTH)) begin
                col_pos = 0;
                n_lines++;
                if (n_lines == 3) begin
                    third_cyc  = cyc_no;
                    await_read = 1'b1;
                end
                if (n_lines >= 3 && n_lines < 64) push_burst(n_lines - 3);
            end
        end else begin
            if (valid && !ready_o) stall_seen++;
            check("wr_en_idle", 32'(wr_en_o), 32'd0);
        end
        @(posedge clk);
        #1;
        cyc_no++;
        if (acc) cur_pix = cur_pix + 8'd1;
    endtask

    task automatic send(input int n, input int budget);
        int sent;
        bit a;
        sent = 0;
        for (int c = 0; c < budget && sent < n; c++) begin
            step(1'b1, 1'b0, a);
            if (a) sent++;
        end
        check("send_count", 32'(sent), 32'(n));
    endtask

    task automatic idle(input int n);
        bit a;
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, a);
    endtask

    task automatic wait_drain(input int budget);
        bit a;
        int c;
        c = 0;
        while ((exp_q.size() != 0 || rd_en_o != 4'b0000 || col_valid_o) && c < budget) begin
            step(1'b0, 1'b0, a);
            c++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_read(input int budget);
        bit a;
        int c;
        c = 0;
        while (rd_en_o == 4'b0000 && c < budget) begin
            step(1'b0, 1'b0, a);
            c++;
        end
        check("read_seen", 32'(rd_en_o != 4'b0000), 32'd1);
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en_o), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
        check({tag, "_col_valid"}, 32'(col_valid_o), 32'd0);
        check({tag, "_cols"}, 32'({col_top_o, col_mid_o, col_bot_o, line_done_o}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        n_vec = 0; n_miss = 0; cyc_no = 0; third_cyc = 0;
        stall_seen = 0; tie_seen = 0;
        cur_pix = 8'd1;
        rst_n = 1'b0; flush_i = 1'b0; pix_valid_i = 1'b0;
        sb_reset();

        // Reset state
        #12;
        check_all_low("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_o), 32'd1);

        // 12 pixels, one idle cycle, then 4 more landing on the first burst's
        // last cycle: line completion and burst end coincide.
        send(12, 40);
        idle(1);
        send(4, 20);
        check("tie_seen", 32'(tie_seen > 0), 32'd1);

        // Continuous source outruns the reads until all four buffers are full.
        send(24, 200);
        check("stall_seen", 32'(stall_seen > 0), 32'd1);

        // Flush in the middle of a burst
        wait_read(60);
        step(1'b0, 1'b1, a);
        flush_i = 1'b0;
        check("flush_rd_en", 32'(rd_en_o), 32'd0);
        check("flush_col_valid", 32'(col_valid_o), 32'd0);
        check("flush_ready", 32'(ready_o), 32'd1);
        sb_reset();

        // Fresh frame after flush behaves like the first one.
        send(12, 40);
        wait_drain(60);

        // Async reset pulse between clock edges during a burst
        send(4, 20);
        wait_read(20);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_low("async_rst");
        sb_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 32'(ready_o), 32'd1);
        check("rst_release_rd_en", 32'(rd_en_o), 32'd0);

        send(12, 40);
        wait_drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
